// File: rtl/rgb_gray_converter.sv
// -----------------------------------------------------------------------------
// rgb_gray_converter
//
// Consumes the R,G,B byte stream from the frame store's read port. Each 3-byte
// pixel becomes one 8-bit luma value. That value goes to the next stage over a
// valid/ready handshake. The frame store is throttled through 'pause'. A
// one-cycle 'gray_done' pulse follows the handshake of the last pixel of a
// frame.
//
// Luma = (WR*R + WG*G + WB*B + 128) >> 8, with the weights in Q0.8.
//
// Optional feature macro: GRAY_BINARIZE_EN
//   When defined, the output is binarized against THRESH (8'hFF / 8'h00).
//   THRESH exists as a parameter only in that build.
//
// Ports
//   clk         in   1  clock, rising edge
//   rst         in   1  synchronous reset, active high
//   gray_enable in   1  start or continue conversion
//   data_in     in   8  RGB byte from frame store, order R,G,B per pixel
//   data_valid  in   1  data_in holds a valid byte
//   pause       out  1  registered; 1 = frame store must hold its address
//   gray_out    out  8  luma pixel
//   gray_valid  out  1  gray_out holds a valid pixel
//   gray_ready  in   1  downstream accepts gray_out
//   gray_done   out  1  one-cycle pulse after the last pixel is accepted
// -----------------------------------------------------------------------------
module rgb_gray_converter #(
  parameter int N      = 480,
  parameter int M      = 320,
  parameter int WR     = 77,
  parameter int WG     = 150,
  parameter int WB     = 29
`ifdef GRAY_BINARIZE_EN
  ,
  parameter int THRESH = 128
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       gray_enable,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       pause,
  output logic [7:0] gray_out,
  output logic       gray_valid,
  input  logic       gray_ready,
  output logic       gray_done
);

  localparam int TOTAL = N * M;
  localparam int CW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  typedef enum logic [2:0] {
    IDLE,
    GET_R,
    GET_G,
    GET_B,
    CALC,
    OUT
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [7:0]    r_q;
  logic [7:0]    g_q;
  logic [7:0]    b_q;
  logic [CW-1:0] pix_cnt;

  logic          in_get;
  logic          consume;
  logic          handshake;
  logic          last_pix;
  logic [7:0]    luma;
  logic [7:0]    pix_val;

  // pause is a registered function of the state. It is 0 only in GET_x. The
  // pause term is therefore redundant with in_get. It is kept so that the
  // acceptance rule reads exactly as the store sees it.
  assign in_get    = state inside {GET_R, GET_G, GET_B};
  assign consume   = data_valid && !pause && in_get;
  assign handshake = (state == OUT) && gray_ready;
  assign last_pix  = (pix_cnt == CW'(TOTAL - 1));

  // The weights sum to 256, so the 17-bit sum never exceeds 65408. Bits
  // [15:8] are the rounded luma. No saturation is needed.
  assign luma = 8'((17'(WR) * 17'(r_q) + 17'(WG) * 17'(g_q)
                  + 17'(WB) * 17'(b_q) + 17'd128) >> 8);

`ifdef GRAY_BINARIZE_EN
  assign pix_val = (luma >= 8'(THRESH)) ? 8'hFF : 8'h00;
`else
  assign pix_val = luma;
`endif

  // NOTE: every output of a combinational block gets a default before the
  // case statement. A path that leaves it unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (gray_enable) state_nxt = GET_R;
      GET_R: if (consume)     state_nxt = GET_G;
      GET_G: if (consume)     state_nxt = GET_B;
      GET_B: if (consume)     state_nxt = CALC;
      CALC:                   state_nxt = OUT;
      OUT: begin
        if (handshake) begin
          // After the last pixel of a frame, or when the controller has
          // withdrawn enable, the FSM parks in IDLE and waits.
          state_nxt = (last_pix || !gray_enable) ? IDLE : GET_R;
        end
      end
      default:                state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples pre-edge values, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pause      <= 1'b1;
      gray_out   <= 8'h00;
      gray_valid <= 1'b0;
      gray_done  <= 1'b0;
      pix_cnt    <= '0;
      // NOTE: the capture registers are cleared as well. A reset mid-pixel
      // then leaves no stale R/G that could leak into the next result.
      r_q        <= 8'h00;
      g_q        <= 8'h00;
      b_q        <= 8'h00;
    end else begin
      state      <= state_nxt;
      pause      <= !(state_nxt inside {GET_R, GET_G, GET_B});
      gray_valid <= (state_nxt == OUT);
      gray_done  <= handshake && last_pix;

      if (consume && state == GET_R) r_q <= data_in;
      if (consume && state == GET_G) g_q <= data_in;
      if (consume && state == GET_B) b_q <= data_in;

      if (state == CALC) gray_out <= pix_val;

      if (handshake) pix_cnt <= last_pix ? '0 : pix_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_rgb_gray_converter.sv
// -----------------------------------------------------------------------------
// tb_rgb_gray_converter
//
// Directed bench for rgb_gray_converter with a 2x2 frame. Inputs are driven,
// and outputs sampled, 1 ns after each rising edge. The expected luma values
// are hand-computed. They are binarized against 128 when GRAY_BINARIZE_EN is
// defined.
// -----------------------------------------------------------------------------
module tb_rgb_gray_converter;

  logic       clk = 1'b0;
  logic       rst;
  logic       gray_enable;
  logic [7:0] data_in;
  logic       data_valid;
  logic       pause;
  logic [7:0] gray_out;
  logic       gray_valid;
  logic       gray_ready;
  logic       gray_done;

  int checks = 0;
  int errors = 0;
  logic [7:0] held;

  always #5 clk = ~clk;

  rgb_gray_converter #(.N(2), .M(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .gray_enable (gray_enable),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .pause       (pause),
    .gray_out    (gray_out),
    .gray_valid  (gray_valid),
    .gray_ready  (gray_ready),
    .gray_done   (gray_done)
  );

  function automatic logic [7:0] expv(input logic [7:0] l);
`ifdef GRAY_BINARIZE_EN
    return (l >= 8'd128) ? 8'hFF : 8'h00;
`else
    return l;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one byte and holds it until the converter consumes it, which it
  // does at the first edge that sees pause=0.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    data_in    = b;
    data_valid = 1'b1;
    while (pause !== 1'b0 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $error("FAIL send_byte_timeout observed=pause_stuck expected=pause_low");
    end else begin
      tick();
    end
    data_valid = 1'b0;
  endtask

  // Streams one pixel. It checks the CALC cycle right after B is captured,
  // then the first OUT cycle (valid visible to the edge two after capture).
  task automatic send_pixel(input logic [7:0] r, input logic [7:0] g,
                            input logic [7:0] b, input logic [7:0] luma,
                            input string tag);
    send_byte(r);
    send_byte(g);
    send_byte(b);
    check({tag, "_calc_valid"}, gray_valid, 0);
    check({tag, "_calc_pause"}, pause, 1);
    tick();
    check({tag, "_out_valid"}, gray_valid, 1);
    check({tag, "_out_pause"}, pause, 1);
    check({tag, "_out_value"}, gray_out, expv(luma));
  endtask

  task automatic handshake(input logic exp_done, input string tag);
    gray_ready = 1'b1;
    tick();
    check({tag, "_done"}, gray_done, exp_done);
  endtask

  initial begin
    rst         = 1'b1;
    gray_enable = 1'b0;
    data_in     = 8'h00;
    data_valid  = 1'b0;
    gray_ready  = 1'b1;
    tick();
    tick();
    check("rst_pause", pause, 1);
    check("rst_valid", gray_valid, 0);
    check("rst_out",   gray_out, 0);
    check("rst_done",  gray_done, 0);

    // IDLE with bytes offered: nothing may be taken while paused.
    rst        = 1'b0;
    data_in    = 8'h55;
    data_valid = 1'b1;
    repeat (3) begin
      tick();
      check("idle_pause", pause, 1);
      check("idle_valid", gray_valid, 0);
    end
    data_valid  = 1'b0;
    gray_enable = 1'b1;

    // Frame 1: four pixels, done only after the fourth handshake.
    send_pixel(8'd255, 8'd255, 8'd255, 8'd255, "white");
    handshake(1'b0, "white");
    send_pixel(8'd0, 8'd0, 8'd0, 8'd0, "black");
    handshake(1'b0, "black");
    send_pixel(8'd255, 8'd0, 8'd0, 8'd77, "red");
    handshake(1'b0, "red");
    send_pixel(8'd0, 8'd255, 8'd0, 8'd149, "green");
    handshake(1'b1, "green_last");
    check("frame_end_cnt",   32'(dut.pix_cnt), 0);
    check("frame_end_pause", pause, 1);
    check("frame_end_valid", gray_valid, 0);
    tick();
    check("done_one_cycle", gray_done, 0);

    // Frame 2, pixel 0, under backpressure with bytes offered.
    gray_ready = 1'b0;
    send_pixel(8'd0, 8'd0, 8'd255, 8'd29, "blue");
    held       = gray_out;
    data_in    = 8'hAA;
    data_valid = 1'b1;
    repeat (6) begin
      tick();
      check("bp_stable", gray_out, held);
      check("bp_pause",  pause, 1);
      check("bp_valid",  gray_valid, 1);
    end
    data_valid = 1'b0;
    handshake(1'b0, "blue");

    // Pixel 1: fresh bytes only; a captured 0xAA would change the result.
    send_pixel(8'd10, 8'd20, 8'd30, 8'd18, "mixed");
    handshake(1'b0, "mixed");

    // Pixel 2 with enable withdrawn: park in IDLE, keep the count.
    send_pixel(8'd255, 8'd255, 8'd255, 8'd255, "white2");
    gray_enable = 1'b0;
    handshake(1'b0, "white2");
    repeat (3) begin
      tick();
      check("parked_pause", pause, 1);
    end
    check("parked_cnt", 32'(dut.pix_cnt), 3);
    gray_enable = 1'b1;
    send_pixel(8'd0, 8'd255, 8'd0, 8'd149, "resume");
    handshake(1'b1, "resume_last");

    // Reset mid-pixel, after R and G of the second pixel of a frame.
    send_pixel(8'd0, 8'd0, 8'd255, 8'd29, "pre_rst");
    handshake(1'b0, "pre_rst");
    send_byte(8'd200);
    send_byte(8'd100);
    rst = 1'b1;
    tick();
    check("midrst_pause", pause, 1);
    check("midrst_valid", gray_valid, 0);
    check("midrst_cnt",   32'(dut.pix_cnt), 0);
    rst = 1'b0;
    send_pixel(8'd10, 8'd20, 8'd30, 8'd18, "post_rst");
    handshake(1'b0, "post_rst");
    check("post_rst_cnt", 32'(dut.pix_cnt), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
